pram_fetch: RTL
===============

Name: pram_fetch

Overview:
Parametrised program RAM with a multi-word instruction fetch engine. It is the successor to the fixed 8-bit × 512, 3-byte program memory.
- A loader writes words through a write port.
- The fetch side reads FETCH_N consecutive words from a requested base address, packs them into one instruction bus, and pulses cmd_start when the bus is valid.
- Sits between the program loader and the control unit / instruction decoder.

Parameters:
- DATA_W, 8: width of one memory word.
- ADDR_W, 9: address width; depth is 2**ADDR_W.
- FETCH_N, 3: words per fetch; legal range 1..8.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wre, input, 1: write enable.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- fetch_req, input, 1: start a fetch; sampled only when busy=0.
- fetch_addr, input, ADDR_W: base address of the fetch; sampled with fetch_req.
- busy, output, 1: high while a fetch is in progress (state != IDLE).
- fetch_data, output, FETCH_N*DATA_W: packed instruction; word i at bits [i*DATA_W +: DATA_W]; word 0 is at the base address.
- cmd_start, output, 1: one-cycle pulse; fetch_data is valid and new.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, cmd_start=0, fetch_data=0, internal word counter=0, base register=0.
  - Memory contents are not cleared and are not written while rst=1.
  - Reset mid-fetch abandons the fetch; no cmd_start is produced.
- Memory: single port, synchronous write, 2**ADDR_W × DATA_W.
  - Write: at the rising edge with wre=1, mem[wr_addr] <= wr_data.
  - The write is accepted in every state and has priority over fetch reads.
- FSM states: IDLE, READ, DONE.
  - IDLE:
    - fetch_req=1 at an edge: latch base=fetch_addr, idx=0, go to READ.
    - fetch_req and wre may both be high in the same cycle: the write completes and the fetch is still accepted.
  - READ:
    - Each edge with wre=0: shadow[idx] <= mem[(base+idx) mod 2**ADDR_W], idx <= idx+1.
    - Each edge with wre=1: the read stalls and idx holds.
    - After the read of idx=FETCH_N-1: copy the whole shadow into fetch_data, set cmd_start=1, go to DONE.
  - DONE (exactly one cycle): cmd_start=1, busy=1. Next edge: cmd_start=0, go to IDLE.
- Latency:
  - No stalls: acceptance edge E0; cmd_start is high in the cycle after edge E(FETCH_N); busy=0 again after edge E(FETCH_N+1).
  - Minimum fetch-to-fetch period: FETCH_N+2 cycles.
  - Each stalled cycle adds 1 cycle.
- fetch_data:
  - Changes only on the edge that raises cmd_start.
  - Holds its value otherwise, including across later fetches until they complete.
- fetch_req while busy=1 is ignored; it is not queued.
- Address arithmetic: base+idx wraps modulo 2**ADDR_W. With defaults, base 510 reads words 510, 511, 0.
- Write/fetch ordering:
  - A write to a window word not yet read returns the new value.
  - A write to a window word already read does not alter the result.
- busy is decoded directly from the state register; no added latency.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-sim.
  - Required: busy=0, cmd_start=0, fetch_data=0 immediately (asynchronously); previously written memory still reads back after reset.
- Basic fetch:
  - Stimulus: write 0x11, 0x22, 0x33 at 0x010..0x012; pulse fetch_req with fetch_addr=0x010.
  - Required: cmd_start is a single pulse in the cycle after edge 3 from acceptance; fetch_data=0x332211; busy high for 4 cycles.
- Wrap-around:
  - Stimulus: write 0xAA@510, 0xBB@511, 0xCC@0; fetch at 510.
  - Required: fetch_data=0xCCBBAA.
- Write stall and ordering:
  - Stimulus: fetch at 0x020 (old data 1,2,3); assert wre for 2 cycles immediately after acceptance, writing 0x99 to 0x022.
  - Required: cmd_start is delayed by 2 cycles; fetch_data=0x990201.
- Ignored request and hold:
  - Stimulus: assert fetch_req with a different address while busy.
  - Required: no extra cmd_start; fetch_data holds its old value until the next accepted fetch completes.
- Abort:
  - Stimulus: assert rst after 1 read of a FETCH_N=3 fetch.
  - Required: no cmd_start; a subsequent fresh fetch returns correct data.
- Parameter sweep:
  - Stimulus: rerun the basic fetch with DATA_W=16, ADDR_W=4, FETCH_N=1 and with FETCH_N=8.
  - Required: latency is FETCH_N+1 cycles to cmd_start; packing is correct.

Source files
------------

// File: rtl/pram_fetch_if.sv
// pram_fetch_if: loader write port and fetch request/result bus for pram_fetch.
interface pram_fetch_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int FETCH_N = 3
);
  logic                      wre;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      fetch_req;
  logic [ADDR_W-1:0]         fetch_addr;
  logic                      busy;
  logic [FETCH_N*DATA_W-1:0] fetch_data;
  logic                      cmd_start;
  modport master (
    output wre, wr_addr, wr_data, fetch_req, fetch_addr,
    input  busy, fetch_data, cmd_start
  );
  modport slave (
    input  wre, wr_addr, wr_data, fetch_req, fetch_addr,
    output busy, fetch_data, cmd_start
  );
endinterface

// File: rtl/pram_fetch.sv
// pram_fetch: program RAM whose fetch engine packs FETCH_N consecutive words into one instruction.
module pram_fetch #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int FETCH_N = 3
) (
  input logic          clk,
  input logic          rst,
  pram_fetch_if.slave  pf
);
  localparam int IDX_W = FETCH_N > 1 ? $clog2(FETCH_N) : 1;
  localparam int BUS_W = FETCH_N * DATA_W;
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BUS_W-1:0]  shadow_q, shadow_d, data_q, data_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              rd_en, last;
  always_ff @(posedge clk)
    if (pf.wre && !rst) mem[pf.wr_addr] <= pf.wr_data;
  // a write in the same cycle owns the port, so the read for idx stalls
  assign rd_en = state_q == READ && !pf.wre;
  assign last  = idx_q == IDX_W'(FETCH_N - 1);
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    if (state_q == IDLE && pf.fetch_req) begin
      state_d = READ;
      base_d  = pf.fetch_addr;
      idx_d   = '0;
    end
    if (rd_en) begin
      shadow_d[idx_q*DATA_W +: DATA_W] = mem[base_q + ADDR_W'(idx_q)];
      idx_d = idx_q + IDX_W'(1);
      if (last) begin
        state_d = DONE;
        data_d  = shadow_d;
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  assign pf.busy       = state_q != IDLE;
  assign pf.cmd_start  = state_q == DONE;
  assign pf.fetch_data = data_q;
endmodule
